// File: rtl/gmm_operand_loader.sv
// Purpose: assembles streamed feature / Gaussian mean+prec vectors into shadow
//          registers and hands complete operand sets to the GMM scoring unit.
// Latency: launch pulses one cycle after the PEND edge where score_ready=1,
//          which is two edges after the last prec word at best (2*DIM+1 cycles/Gaussian).
// Backpressure: s_tready drops only while a complete set waits in PEND for score_ready.
//
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast  AXI-Stream-style word input
//   s_tuser                            1 = feature packet, 0 = Gaussian packet (first word)
//   score_ready                        scoring pipeline accepts a launch this cycle
//   feature_flat/mean_flat/prec_flat   active operand vectors, element i at [i*W +: W]
//   launch, launch_idx, frame_start    one-cycle launch pulse with its Gaussian index
//   err                                sticky protocol error
module gmm_operand_loader #(
  parameter int DIM  = 29,
  parameter int W    = 32,
  parameter int IDXW = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [W-1:0]        s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                s_tuser,
  input  logic                score_ready,
  output logic [DIM*W-1:0]    feature_flat,
  output logic [DIM*W-1:0]    mean_flat,
  output logic [DIM*W-1:0]    prec_flat,
  output logic                launch,
  output logic [IDXW-1:0]     launch_idx,
  output logic                frame_start,
  output logic                err
);

  localparam int WCW = $clog2(DIM);
  localparam logic [WCW-1:0] LAST = WCW'(DIM - 1);

  typedef enum logic [2:0] {IDLE, FEAT, MEAN, PREC, PEND, DROP} state_t;

  state_t              state;
  logic [WCW-1:0]      wc;
  logic [IDXW-1:0]     gidx;
  logic                feat_loaded;
  logic                new_frame;
  logic [DIM*W-1:0]    feat_sh;
  logic [DIM*W-1:0]    mean_sh;
  logic [DIM*W-1:0]    prec_sh;
  logic                accept;

  // Gated by aresetn so the port reads 0 while reset is held.
  assign s_tready = aresetn && (state != PEND);
  assign accept   = s_tvalid && s_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      wc           <= '0;
      gidx         <= '0;
      feat_loaded  <= 1'b0;
      new_frame    <= 1'b0;
      feat_sh      <= '0;
      mean_sh      <= '0;
      prec_sh      <= '0;
      feature_flat <= '0;
      mean_flat    <= '0;
      prec_flat    <= '0;
      launch       <= 1'b0;
      launch_idx   <= '0;
      frame_start  <= 1'b0;
      err          <= 1'b0;
    end else begin
      launch      <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wc <= WCW'(1);
            if (s_tuser) begin
              feat_sh[0 +: W] <= s_tdata;
              // The feature shadow is being overwritten, so the old vector is
              // gone; only a complete new packet may re-enable Gaussians.
              feat_loaded <= 1'b0;
              if (s_tlast) err <= 1'b1;
              else         state <= FEAT;
            end else begin
              mean_sh[0 +: W] <= s_tdata;
              if (!feat_loaded) begin
                err <= 1'b1;
                if (!s_tlast) state <= DROP;
              end else if (s_tlast) begin
                err <= 1'b1;
              end else begin
                state <= MEAN;
              end
            end
          end
        end
        FEAT: begin
          if (accept) begin
            feat_sh[wc*W +: W] <= s_tdata;
            wc <= wc + 1'b1;
            if (wc == LAST) begin
              if (s_tlast) begin
                feat_loaded <= 1'b1;
                new_frame   <= 1'b1;
                gidx        <= '0;
                state       <= IDLE;
              end else begin
                err   <= 1'b1;
                state <= DROP;
              end
            end else if (s_tlast) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        MEAN: begin
          if (accept) begin
            mean_sh[wc*W +: W] <= s_tdata;
            // A Gaussian packet can never legally end inside the mean half.
            if (s_tlast) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (wc == LAST) begin
              wc    <= '0;
              state <= PREC;
            end else begin
              wc <= wc + 1'b1;
            end
          end
        end
        PREC: begin
          if (accept) begin
            prec_sh[wc*W +: W] <= s_tdata;
            wc <= wc + 1'b1;
            if (wc == LAST) begin
              if (s_tlast) begin
                state <= PEND;
              end else begin
                err   <= 1'b1;
                state <= DROP;
              end
            end else if (s_tlast) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        PEND: begin
          if (score_ready) begin
            feature_flat <= feat_sh;
            mean_flat    <= mean_sh;
            prec_flat    <= prec_sh;
            launch       <= 1'b1;
            launch_idx   <= gidx;
            gidx         <= gidx + 1'b1;
            frame_start  <= new_frame;
            new_frame    <= 1'b0;
            state        <= IDLE;
          end
        end
        DROP: begin
          if (accept && s_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gmm_operand_loader.md
# gmm_operand_loader

Streaming front end for the GMM scoring datapath. Receives one 32-bit word per beat on an AXI-Stream-style slave port and assembles the 29-element feature vector and the per-Gaussian mean/precision vectors into shadow registers. It then transfers each complete operand set to stable active registers with a one-cycle launch pulse. The active registers drive the feature/mean/prec operand inputs of the GMM scoring unit directly.

## Interface
- DIM, 29, vector dimension (elements per feature/mean/prec vector)
- W, 32, word width (IEEE-754 single, passed through untouched)
- IDXW, 16, width of Gaussian index counter
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_tdata  in  W  stream word
- s_tvalid  in  1  word valid
- s_tready  out  1  loader can accept word
- s_tlast  in  1  last word of packet
- s_tuser  in  1  packet type, sampled on first word of packet: 1 = feature packet, 0 = Gaussian packet
- score_ready  in  1  scoring pipeline can take a new operand set this cycle
- feature_flat  out  DIM*W  active feature vector, element i at [i*W +: W]
- mean_flat  out  DIM*W  active mean vector, same packing
- prec_flat  out  DIM*W  active precision vector, same packing
- launch  out  1  one-cycle pulse: active registers just updated
- launch_idx  out  IDXW  Gaussian index of the launched set
- frame_start  out  1  high with launch for first Gaussian after a new feature packet
- err  out  1  sticky protocol error, cleared only by reset

## Operation
- Beat accepted when s_tvalid && s_tready at a rising edge.
- Feature packet: exactly DIM words, feature[0..DIM-1], s_tlast on word DIM-1.
- Gaussian packet: exactly 2*DIM words, mean[0..DIM-1] then prec[0..DIM-1], s_tlast on word 2*DIM-1.
- FSM states: IDLE, FEAT, MEAN, PREC, PEND, DROP.
  - IDLE: the first accepted word selects the path by s_tuser. It is written to element 0 and the word counter wc is set to 1.
    - s_tuser=1 goes to FEAT.
    - s_tuser=0 goes to MEAN, but only if feat_loaded. Otherwise err is set and the FSM goes to DROP (or stays in IDLE if the word carries s_tlast).
  - FEAT: writes feature shadow[wc].
    - Word DIM-1 with s_tlast: set feat_loaded and new_frame, then go to IDLE.
  - MEAN: writes mean shadow[wc]. After word DIM-1, wc clears and the FSM goes to PREC.
  - PREC: writes prec shadow[wc].
    - Word DIM-1 with s_tlast: go to PEND.
  - PEND: s_tready=0.
    - On an edge with score_ready=1, the active feature/mean/prec registers load from the shadows and launch is asserted for the following cycle.
    - launch_idx takes gidx, then gidx increments (wraps modulo 2^IDXW).
    - frame_start equals new_frame, and new_frame clears. Then go to IDLE.
  - DROP: discards words until s_tlast is accepted, then goes to IDLE. Shadow contents are undefined; active registers are untouched.
- Length errors:
  - s_tlast before the final word, or missing on the final word, sets err.
  - Early s_tlast: go to IDLE.
  - Missing s_tlast: go to DROP.
  - Partial data is never launched.
- Feature packet completion zeroes gidx. Active feature_flat changes only at launch, never mid-packet.
- s_tready is 1 in IDLE, FEAT, MEAN, PREC and DROP, and 0 only in PEND.
- Reset (asynchronous, any state, mid-packet included) clears the following:
  - FSM to IDLE; wc, gidx, feat_loaded and new_frame to 0.
  - All active/shadow registers to 0.
  - launch=0, frame_start=0, launch_idx=0, err=0.
  - s_tready=1 once aresetn is deasserted.

## Timing
- Last prec word accepted at edge k; PEND during cycle k..k+1.
- If score_ready=1 at edge k+1, launch, frame_start and the active registers are valid in the cycle after edge k+1.
- Throughput: 2*DIM+1 cycles per Gaussian at full s_tvalid, i.e. 59 cycles for DIM=29.
- A score_ready stall holds PEND and s_tready=0 indefinitely, with no data loss.
- launch is never high for two consecutive cycles.
- The active operand registers stay stable from one launch until the next.

## Test plan
- Reset with aresetn low → s_tready=0 during reset; after release s_tready=1, launch=0, err=0, all flats 0.
- Feature packet 0x3F800000..(+i) followed by a Gaussian packet, with score_ready=1 → single launch 59 cycles after the first Gaussian word. Also requires frame_start=1, launch_idx=0, every element matching, err=0.
- Three Gaussians back-to-back → launch_idx 0,1,2 with frame_start only on the first. A new feature packet then another Gaussian → launch_idx 0, frame_start=1.
- Gaussian packet before any feature packet → err=1, no launch. The following valid feature+Gaussian pair still launches.
- Gaussian packet with s_tlast on word 40 → err=1, no launch, FSM back in IDLE. The next good packet launches with correct data.
- score_ready held 0 for 10 cycles in PEND → s_tready=0 throughout and launch withheld. Releasing score_ready gives exactly one launch one cycle later. Pulling aresetn low mid-MEAN → all outputs return to reset values immediately.
